// File: rtl/mem_arbiter.sv
// Single-port memory arbiter (video > DMA > CPU) with the $4014 OAM sprite-DMA sequencer.
// The owner comes only from registered state and vid_req, so there is no path from the CPU address.
module mem_arbiter #(
    parameter int          VID_BURST = 8,
    parameter logic [15:0] DMA_REG   = 16'h4014
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    output logic        cpu_locked,
    output logic [7:0]  cpu_rdata,
    input  logic        vid_req,
    input  logic [15:0] vid_addr,
    output logic        vid_ack,
    output logic [7:0]  vid_rdata,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic        oam_we,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data,
    output logic        dma_busy
);

    localparam logic [7:0] BURST_LIMIT = 8'(VID_BURST);

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_START,
        DMA_RUN,
        DMA_DRAIN
    } dmaState_t;

    dmaState_t   r_dmaState;
    dmaState_t   w_dmaNext;
    logic [7:0]  r_vcnt;
    logic [7:0]  r_cnt;
    logic [7:0]  r_page;
    logic        r_oamWe;
    logic [7:0]  r_oamAddr;
    logic [7:0]  r_oamData;

    logic        w_vidForce;
    logic        w_ownVid;
    logic        w_ownDma;
    logic        w_ownCpu;
    logic        w_dmaTrigger;

    // After VID_BURST back-to-back video grants, video sits out exactly one cycle.
    assign w_vidForce   = (r_vcnt == BURST_LIMIT);
    assign w_ownVid     = resetn & vid_req & ~w_vidForce;
    assign w_ownDma     = resetn & ~w_ownVid & (r_dmaState == DMA_RUN);
    assign w_ownCpu     = resetn & ~w_ownVid & (r_dmaState == DMA_IDLE);
    assign w_dmaTrigger = w_ownCpu & cpu_we & (cpu_address == DMA_REG);

    assign cpu_rdata = mem_rdata;
    assign vid_rdata = mem_rdata;
    assign dma_busy  = (r_dmaState != DMA_IDLE);
    assign oam_we    = r_oamWe;
    assign oam_addr  = r_oamAddr;
    assign oam_data  = r_oamData;

    always_comb begin
        mem_address = cpu_address;
        mem_wdata   = cpu_wdata;
        mem_we      = 1'b0;
        cpu_locked  = 1'b0;
        vid_ack     = 1'b0;
        if (w_ownVid) begin
            mem_address = vid_addr;
            vid_ack     = 1'b1;
        end else if (w_ownDma) begin
            mem_address = {r_page, r_cnt};
        end else if (w_ownCpu) begin
            cpu_locked = 1'b1;
            mem_we     = cpu_we & ~w_dmaTrigger;
        end
    end

    always_comb begin
        w_dmaNext = r_dmaState;
        case (r_dmaState)
            DMA_IDLE:  if (w_dmaTrigger) w_dmaNext = DMA_START;
            DMA_START: w_dmaNext = DMA_RUN;
            DMA_RUN:   if (w_ownDma && (r_cnt == 8'hFF)) w_dmaNext = DMA_DRAIN;
            DMA_DRAIN: w_dmaNext = DMA_IDLE;
            default:   w_dmaNext = DMA_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_dmaState <= DMA_IDLE;
        end else begin
            r_dmaState <= w_dmaNext;
        end
    end

    // Byte read on a DMA-owned cycle is written into OAM on the following cycle.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_vcnt    <= 8'd0;
            r_cnt     <= 8'd0;
            r_page    <= 8'd0;
            r_oamWe   <= 1'b0;
            r_oamAddr <= 8'd0;
            r_oamData <= 8'd0;
        end else begin
            r_vcnt  <= w_ownVid ? (r_vcnt + 8'd1) : 8'd0;
            r_oamWe <= w_ownDma;
            if (w_dmaTrigger) begin
                r_page <= cpu_wdata;
            end
            if (r_dmaState == DMA_START) begin
                r_cnt <= 8'd0;
            end else if (w_ownDma) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_ownDma) begin
                r_oamAddr <= r_cnt;
                r_oamData <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural 64 KB memory, CPU/video stimulus,
// and a queue of expected OAM writes consumed by a monitor.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        resetn;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic        cpu_locked;
    logic [7:0]  cpu_rdata;
    logic        vid_req;
    logic [15:0] vid_addr;
    logic        vid_ack;
    logic [7:0]  vid_rdata;
    logic [15:0] mem_address;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic        oam_we;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data;
    logic        dma_busy;

    logic [7:0]  mem [0:65535];
    logic        memInit = 1'b0;
    logic [15:0] expQ [$];
    int          compareCount = 0;
    int          mismatchCount = 0;
    int          oamPulses = 0;

    mem_arbiter #(.VID_BURST(8), .DMA_REG(16'h4014)) dut (
        .clock(clock), .resetn(resetn),
        .cpu_address(cpu_address), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .cpu_locked(cpu_locked), .cpu_rdata(cpu_rdata),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .oam_we(oam_we), .oam_addr(oam_addr), .oam_data(oam_data), .dma_busy(dma_busy)
    );

    always #20 clock = ~clock;

    function automatic logic [7:0] initByte(input logic [15:0] a);
        case (a[15:8])
            8'h02:   return a[7:0] ^ 8'hFF;
            8'h05:   return a[7:0] + 8'h07;
            default: return a[7:0] ^ a[15:8];
        endcase
    endfunction

    // Combinational-read memory; the whole array is filled on the first edge (inside reset).
    assign mem_rdata = mem[mem_address];
    always @(posedge clock) begin
        if (!memInit) begin
            for (int a = 0; a < 65536; a++) mem[a[15:0]] <= initByte(a[15:0]);
            memInit <= 1'b1;
        end else if (mem_we) begin
            mem[mem_address] <= mem_wdata;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] wdata, input logic we,
                                 input logic vreq, input logic [15:0] vaddr);
        @(posedge clock);
        #1;
        cpu_address = addr;
        cpu_wdata   = wdata;
        cpu_we      = we;
        vid_req     = vreq;
        vid_addr    = vaddr;
        @(negedge clock);
    endtask

    task automatic pushPage(input logic [7:0] page);
        for (int i = 0; i < 256; i++) expQ.push_back({i[7:0], initByte({page, i[7:0]})});
    endtask

    // Every OAM write must match the oldest expected entry; any write with nothing expected is an error.
    always @(negedge clock) begin
        if (memInit && resetn && oam_we) begin
            oamPulses++;
            if (expQ.size() > 0) begin
                logic [15:0] e;
                e = expQ.pop_front();
                checkOutput("oam_write", 32'({oam_addr, oam_data}), 32'(e));
            end else begin
                checkOutput("oam_unexpected", 32'(oam_we), 32'd0);
            end
        end
    end

    initial begin
        #(40 * 5000);
        $display("[TB] FAIL watchdog: simulation did not finish within cycle budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  lowCount;
        int  weCount;
        int  firstOam;
        int  pulseStart;
        bit  done;
        bit  prevAck;
        bit  expAck;

        resetn      = 1'b0;
        cpu_address = 16'h4014;
        cpu_wdata   = 8'h02;
        cpu_we      = 1'b1;
        vid_req     = 1'b1;
        vid_addr    = 16'h0300;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("rst_locked", 32'(cpu_locked), 32'd0);
        checkOutput("rst_memwe", 32'(mem_we), 32'd0);
        checkOutput("rst_vidack", 32'(vid_ack), 32'd0);
        checkOutput("rst_busy", 32'(dma_busy), 32'd0);
        checkOutput("rst_oam", 32'({oam_we, oam_addr, oam_data}), 32'd0);

        @(posedge clock);
        #1 resetn = 1'b1;
        applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000);
        checkOutput("idle_locked", 32'(cpu_locked), 32'd1);

        $display("[TB] uncontended sprite DMA from page $02");
        pushPage(8'h02);
        pulseStart = oamPulses;
        applyStimulus(16'h4014, 8'h02, 1'b1, 1'b0, 16'h0000);
        checkOutput("dma_trig_memwe", 32'(mem_we), 32'd0);
        checkOutput("dma_trig_locked", 32'(cpu_locked), 32'd1);
        lowCount = 0; weCount = 0; firstOam = -1; done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000);
            if (k == 0) checkOutput("dma_busy_start", 32'(dma_busy), 32'd1);
            if (mem_we) weCount++;
            if (oam_we && firstOam < 0) firstOam = k;
            if (cpu_locked) done = 1'b1;
            else lowCount++;
        end
        checkOutput("dma_relocked", 32'(done), 32'd1);
        checkOutput("dma_lock_low_cycles", 32'(lowCount), 32'd258);
        checkOutput("dma_memwe_cycles", 32'(weCount), 32'd0);
        checkOutput("dma_first_oam_latency", 32'(firstOam), 32'd2);
        checkOutput("dma_pulses", 32'(oamPulses - pulseStart), 32'd256);
        checkOutput("dma_queue_left", 32'(expQ.size()), 32'd0);
        checkOutput("dma_busy_end", 32'(dma_busy), 32'd0);

        $display("[TB] CPU write then read back at $0200");
        applyStimulus(16'h0200, 8'h5A, 1'b1, 1'b0, 16'h0000);
        checkOutput("cpu_wr_locked", 32'(cpu_locked), 32'd1);
        checkOutput("cpu_wr_memwe", 32'(mem_we), 32'd1);
        checkOutput("cpu_wr_addr", 32'(mem_address), 32'h0200);
        applyStimulus(16'h0200, 8'h00, 1'b0, 1'b0, 16'h0000);
        checkOutput("cpu_rd_locked", 32'(cpu_locked), 32'd1);
        checkOutput("cpu_rd_memwe", 32'(mem_we), 32'd0);
        checkOutput("cpu_rd_data", 32'(cpu_rdata), 32'h5A);

        $display("[TB] continuous video request, burst of 8");
        for (int k = 0; k < 27; k++) begin
            applyStimulus(16'h0123, 8'h00, 1'b0, 1'b1, 16'h0300);
            expAck = ((k % 9) != 8);
            checkOutput("burst_ack", 32'(vid_ack), 32'(expAck));
            checkOutput("burst_locked", 32'(cpu_locked), 32'(!expAck));
            if (expAck) checkOutput("burst_vid_rdata", 32'(vid_rdata), 32'(initByte(16'h0300)));
            else checkOutput("burst_cpu_addr", 32'(mem_address), 32'h0123);
        end

        $display("[TB] CPU write colliding with video request");
        applyStimulus(16'h1234, 8'hA7, 1'b1, 1'b1, 16'h0300);
        checkOutput("coll_vidack", 32'(vid_ack), 32'd1);
        checkOutput("coll_locked", 32'(cpu_locked), 32'd0);
        checkOutput("coll_memwe", 32'(mem_we), 32'd0);
        applyStimulus(16'h1234, 8'hA7, 1'b1, 1'b0, 16'h0300);
        checkOutput("retry_locked", 32'(cpu_locked), 32'd1);
        checkOutput("retry_memwe", 32'(mem_we), 32'd1);
        checkOutput("retry_wr", 32'({mem_address, mem_wdata}), 32'h1234A7);
        applyStimulus(16'h1234, 8'h00, 1'b0, 1'b0, 16'h0300);
        checkOutput("retry_readback", 32'(cpu_rdata), 32'hA7);

        $display("[TB] sprite DMA from page $05 with video every third cycle");
        pushPage(8'h05);
        pulseStart = oamPulses;
        applyStimulus(16'h4014, 8'h05, 1'b1, 1'b0, 16'h0310);
        checkOutput("dma3_trig_memwe", 32'(mem_we), 32'd0);
        prevAck = 1'b0; done = 1'b0;
        for (int k = 0; k < 600 && !done; k++) begin
            applyStimulus(16'h0000, 8'h00, 1'b0, ((k % 3) == 0), 16'h0310);
            if (prevAck) checkOutput("dma3_oam_gap", 32'(oam_we), 32'd0);
            if (mem_we) checkOutput("dma3_memwe", 32'(mem_we), 32'd0);
            if (dma_busy) begin
                if (cpu_locked) checkOutput("dma3_locked", 32'(cpu_locked), 32'd0);
            end else begin
                done = 1'b1;
            end
            prevAck = vid_ack;
        end
        checkOutput("dma3_done", 32'(done), 32'd1);
        checkOutput("dma3_pulses", 32'(oamPulses - pulseStart), 32'd256);
        checkOutput("dma3_queue_left", 32'(expQ.size()), 32'd0);

        $display("[TB] reset during sprite DMA");
        pushPage(8'h05);
        applyStimulus(16'h4014, 8'h05, 1'b1, 1'b0, 16'h0000);
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000);
            if (oam_we && oam_addr == 8'd100) done = 1'b1;
        end
        checkOutput("abort_reached_byte100", 32'(done), 32'd1);
        @(posedge clock);
        #1;
        resetn  = 1'b0;
        vid_req = 1'b1;
        cpu_we  = 1'b1;
        cpu_address = 16'h0400;
        @(negedge clock);
        checkOutput("abort_rst_locked", 32'(cpu_locked), 32'd0);
        checkOutput("abort_rst_memwe", 32'(mem_we), 32'd0);
        checkOutput("abort_rst_vidack", 32'(vid_ack), 32'd0);
        @(posedge clock);
        #1 expQ.delete();
        @(negedge clock);
        checkOutput("abort_oamwe", 32'(oam_we), 32'd0);
        checkOutput("abort_busy", 32'(dma_busy), 32'd0);
        @(posedge clock);
        #1 resetn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000);
            checkOutput("post_abort_oamwe", 32'(oam_we), 32'd0);
            checkOutput("post_abort_busy", 32'(dma_busy), 32'd0);
            checkOutput("post_abort_locked", 32'(cpu_locked), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and OAM sprite-DMA sequencer sitting between the 6502 core, the video fetch unit and the shared 64 KB memory. Each cycle it grants the bus to exactly one owner: video, DMA or CPU, in that priority order. It stalls the CPU through its `locked` clock-enable. A CPU write to $4014 launches a 256-byte page copy from memory into OAM.

## Interface
Parameters:
- VID_BURST, 8, max consecutive video-granted cycles before one forced non-video cycle (1..255)
- DMA_REG, 16'h4014, CPU address that triggers sprite DMA

Ports:
- clock  in  1  system clock (25 MHz)
- resetn  in  1  synchronous, active-low reset
- cpu_address  in  16  CPU bus address
- cpu_wdata  in  8  CPU write data (CPU `o_data`)
- cpu_we  in  1  CPU write request
- cpu_locked  out  1  CPU clock-enable; 1 = CPU owns bus this cycle
- cpu_rdata  out  8  read data to CPU (`i_data`)
- vid_req  in  1  video fetch request, level, held until acked
- vid_addr  in  16  video fetch address
- vid_ack  out  1  video granted this cycle; vid_rdata valid
- vid_rdata  out  8  video read data
- mem_address  out  16  memory address
- mem_wdata  out  8  memory write data
- mem_we  out  1  memory write strobe
- mem_rdata  in  8  memory read data, valid same cycle as mem_address (combinational read)
- oam_we  out  1  OAM write strobe
- oam_addr  out  8  OAM byte index
- oam_data  out  8  OAM write data
- dma_busy  out  1  DMA in progress

## Operation
- Owner is selected combinationally from registered state and vid_req only; never from CPU address/data (no loop through CPU `address`).
- Owner priority: VID if vid_req and not forced-off; else DMA if DMA state RUN; else CPU unless DMA state is START/RUN/DRAIN; else none.
- VID: mem_address=vid_addr, mem_we=0, vid_ack=1, vid_rdata=mem_rdata.
- CPU: cpu_locked=1, mem_address=cpu_address, mem_wdata=cpu_wdata, mem_we=cpu_we, except a write to DMA_REG, which is absorbed (mem_we=0) and latches page<=cpu_wdata and starts DMA.
- Non-owner CPU: cpu_locked=0. The CPU holds its registered we/address, so a blocked write is retried on the next grant. A write is never forwarded without a grant.
- cpu_rdata = mem_rdata always; it is meaningful only when cpu_locked=1.
- Burst counter vcnt: increments on each VID cycle and clears on any non-VID cycle. When vcnt==VID_BURST, the next cycle forces video off (vid_ack=0) for exactly one cycle, and the lower priority is served in that cycle.
- DMA FSM:
  - IDLE -> START on absorbed DMA_REG write.
  - START -> RUN after one cycle; cnt=0.
  - RUN: on each DMA-owned cycle, mem_address={page,cnt}, mem_we=0, captured byte registered to oam_data, oam_addr<=cnt, oam_we<=1 next cycle, cnt+1. Cycles lost to video produce oam_we=0 next cycle, and cnt holds.
  - RUN -> DRAIN when the cnt==255 read is granted.
  - DRAIN -> IDLE after one cycle; the last OAM write occurs in this cycle.
- dma_busy=1 in START/RUN/DRAIN.
- cnt is 8 bits; exactly 256 bytes are copied; page+cnt never carries into the high byte.
- A DMA_REG write is impossible while busy because the CPU is locked.

## Timing
- Reset (resetn=0 at a clock edge): DMA->IDLE, cnt=0, vcnt=0, page=0, oam_we=0, oam_addr=0, oam_data=0. While resetn=0, cpu_locked=0, mem_we=0 and vid_ack=0 combinationally.
- Reset mid-DMA aborts with no further OAM writes.
- Grant latency: 0 cycles (same-cycle combinational grant).
- OAM write latency: 1 cycle after the DMA read.
- Uncontended DMA: cycle of $4014 write = W; START at W+1; reads W+2..W+257; OAM writes W+3..W+258; CPU regains lock at W+259.
- Video continuously requesting: pattern is VID_BURST video cycles, then 1 other cycle, repeating. The CPU or DMA is never fully starved.
- vid_req and a CPU write in the same cycle: video wins, the CPU stalls, and no memory write occurs.

## Test plan
- CPU alone, writes $5A to $0200 then reads it back: cpu_locked=1 every cycle, mem_we=1 exactly one cycle, read returns $5A.
- CPU writes $02 to $4014 with memory $0200+i=i^$FF, no video: mem_we stays 0; exactly 256 oam_we pulses with oam_addr 0..255 and oam_data=i^$FF; cpu_locked=0 for exactly 258 cycles.
- vid_req held high, VID_BURST=8, CPU active: vid_ack is 8 high, 1 low, repeating; cpu_locked=1 only in the low cycles.
- Video pulses every 3rd cycle during DMA: OAM still receives all 256 correct bytes in order, with oam_we gaps matching the video cycles.
- CPU write to $1234 coincident with vid_req: no mem_we that cycle; write lands on the next CPU grant with the same data.
- resetn=0 at DMA byte 100: oam_we=0 thereafter, dma_busy=0, and the CPU is relocked after reset release.
